// File: rtl/hb_load_store_master.sv
// hb_load_store_master: turns one CPU load/store into an XT high-speed bus access
// with alignment check, load extension and a wait_finish timeout.
module hb_load_store_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        hb_clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misalign,
   output logic        rsp_timeout,
   output logic [31:0] hb_raddr,
   output logic [31:0] hb_waddr,
   output logic [31:0] hb_wdata,
   output logic [1:0]  hb_write_width,
   output logic        hb_ren,
   output logic        hb_wen,
   input  logic [31:0] hb_rdata,
   input  logic        hb_wait_finish
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   state_t        state;
   logic [1:0]    width, f_width;
   logic          uns, misalign, expire;
   logic [CW-1:0] cnt;
   logic [31:0]   ext;
   // funct3 011/11x collapse to word
   always_comb begin
      f_width = req_funct3[1] ? 2'd2 : {1'b0, req_funct3[0]};
      misalign = (f_width == 2'd1 && req_addr[0]) || (f_width == 2'd2 && req_addr[1:0] != 2'd0);
      expire = cnt == CW'(TIMEOUT_CYCLES - 1);
      ext = width == 2'd0 ? {{24{hb_rdata[7] & ~uns}}, hb_rdata[7:0]} :
            width == 2'd1 ? {{16{hb_rdata[15] & ~uns}}, hb_rdata[15:0]} : hb_rdata;
   end
   always_ff @(posedge hb_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_misalign <= 1'b0;
         rsp_timeout <= 1'b0;
         hb_raddr <= '0;
         hb_waddr <= '0;
         hb_wdata <= '0;
         hb_write_width <= '0;
         hb_ren <= 1'b0;
         hb_wen <= 1'b0;
         width <= '0;
         uns <= 1'b0;
         cnt <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_misalign <= 1'b0;
         rsp_timeout <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               width <= f_width;
               uns <= req_funct3[2];
               cnt <= '0;
               req_ready <= 1'b0;
               if (misalign) begin
                  state <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_misalign <= 1'b1;
               end else if (req_we) begin
                  state <= WR;
                  hb_wen <= 1'b1;
                  hb_waddr <= req_addr;
                  hb_wdata <= req_wdata;
                  hb_write_width <= f_width;
               end else begin
                  state <= RD;
                  hb_ren <= 1'b1;
                  hb_raddr <= req_addr;
               end
            end
            RD, WR: if (hb_wait_finish || expire) begin
               state <= RESP;
               hb_ren <= 1'b0;
               hb_wen <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_timeout <= ~hb_wait_finish;
               rsp_rdata <= (state == RD && hb_wait_finish) ? ext : '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: begin
               state <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_hb_load_store_master.sv
// tb_hb_load_store_master: directed load/store vectors against a small bus responder
// whose finish behaviour is selected per test.
module tb_hb_load_store_master;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_misalign, rsp_timeout;
   logic [31:0] rsp_rdata, hb_raddr, hb_waddr, hb_wdata, hb_rdata;
   logic [1:0]  hb_write_width;
   logic        hb_ren, hb_wen, hb_wait_finish;
   int          errors = 0, checks = 0, both_high = 0;
   int          mode = 0;
   logic        fin_r = 1'b0;
   logic [31:0] bus_data = '0;

   always #5 clk = ~clk;

   // mode 0: never finish, 1: registered finish one cycle after ren, 2: finish tied high
   always @(posedge clk) fin_r <= (mode == 1) && hb_ren && !fin_r;
   assign hb_wait_finish = (mode == 2) ? 1'b1 : fin_r;
   assign hb_rdata = bus_data;

   always @(negedge clk) if (hb_ren && hb_wen) both_high++;

   hb_load_store_master #(.TIMEOUT_CYCLES(16)) dut (
      .hb_clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
      .rsp_timeout(rsp_timeout), .hb_raddr(hb_raddr), .hb_waddr(hb_waddr), .hb_wdata(hb_wdata),
      .hb_write_width(hb_write_width), .hb_ren(hb_ren), .hb_wen(hb_wen), .hb_rdata(hb_rdata),
      .hb_wait_finish(hb_wait_finish)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   int          r_cyc, r_ren, r_wen, r_ready1;
   logic [31:0] r_rdata, r_raddr, r_waddr, r_wdata;
   logic        r_mis, r_to;
   logic [1:0]  r_ww;

   // issue one request (accepted in c0) and watch cycles c1.. until rsp_valid
   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
      r_cyc = 0; r_ren = 0; r_wen = 0; r_ready1 = 1;
      r_rdata = '0; r_raddr = '0; r_waddr = '0; r_wdata = '0; r_mis = 0; r_to = 0; r_ww = '0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0;
            r_ready1 = int'(req_ready);
         end
         if (hb_ren) begin
            r_ren++;
            r_raddr = hb_raddr;
         end
         if (hb_wen) begin
            r_wen++;
            r_waddr = hb_waddr; r_wdata = hb_wdata; r_ww = hb_write_width;
         end
         if (rsp_valid) begin
            r_cyc = c; r_rdata = rsp_rdata; r_mis = rsp_misalign; r_to = rsp_timeout;
            break;
         end
      end
      check("rsp_seen", 32'(r_cyc != 0), 32'd1);
      check("ready_c1", 32'(r_ready1), 32'd0);
      @(negedge clk);
      check("pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
      check("rdata_cleared", rsp_rdata, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_strobes", {30'd0, hb_ren, hb_wen}, 32'd0);
      check("rst_rsp", {29'd0, rsp_valid, rsp_misalign, rsp_timeout}, 32'd0);
      check("rst_raddr", hb_raddr, 32'd0);
      check("rst_ww", {30'd0, hb_write_width}, 32'd0);
      rst_n = 1'b1;

      mode = 1; bus_data = 32'h0000_00F0;
      access(1'b0, 3'b000, 32'h103, 32'd0);
      check("lb_cyc", r_cyc, 32'd3);
      check("lb_ren", r_ren, 32'd2);
      check("lb_raddr", r_raddr, 32'h103);
      check("lb_rdata", r_rdata, 32'hFFFF_FFF0);
      check("lb_flags", {30'd0, r_mis, r_to}, 32'd0);

      access(1'b0, 3'b100, 32'h101, 32'd0);
      check("lbu_rdata", r_rdata, 32'h0000_00F0);

      bus_data = 32'h0000_8001;
      access(1'b0, 3'b101, 32'h102, 32'd0);
      check("lhu_rdata", r_rdata, 32'h0000_8001);
      access(1'b0, 3'b001, 32'h102, 32'd0);
      check("lh_rdata", r_rdata, 32'hFFFF_8001);

      bus_data = 32'hDEAD_BEEF;
      access(1'b0, 3'b010, 32'h104, 32'd0);
      check("lw_rdata", r_rdata, 32'hDEAD_BEEF);

      mode = 2;
      access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
      check("sh_cyc", r_cyc, 32'd2);
      check("sh_wen", r_wen, 32'd1);
      check("sh_ren", r_ren, 32'd0);
      check("sh_waddr", r_waddr, 32'h202);
      check("sh_wdata", r_wdata, 32'h1234_ABCD);
      check("sh_ww", {30'd0, r_ww}, 32'd1);
      check("sh_rdata", r_rdata, 32'd0);

      access(1'b1, 3'b000, 32'h303, 32'h0000_00A5);
      check("sb_ww", {30'd0, r_ww}, 32'd0);
      check("sb_waddr", r_waddr, 32'h303);

      mode = 1;
      access(1'b0, 3'b010, 32'h101, 32'd0);
      check("lw_mis_cyc", r_cyc, 32'd1);
      check("lw_mis_flag", {30'd0, r_mis, r_to}, 32'd2);
      check("lw_mis_strobes", r_ren + r_wen, 32'd0);
      mode = 2;
      access(1'b1, 3'b001, 32'h103, 32'h5555_5555);
      check("sh_mis_cyc", r_cyc, 32'd1);
      check("sh_mis_flag", {30'd0, r_mis, r_to}, 32'd2);
      check("sh_mis_strobes", r_ren + r_wen, 32'd0);

      mode = 0; bus_data = 32'hFFFF_FFFF;
      access(1'b0, 3'b010, 32'h400, 32'd0);
      check("to_ren", r_ren, 32'd16);
      check("to_cyc", r_cyc, 32'd17);
      check("to_flag", {30'd0, r_mis, r_to}, 32'd1);
      check("to_rdata", r_rdata, 32'd0);

      // async reset in the second cycle of a load
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_mid_ren_before", {31'd0, hb_ren}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ren", {31'd0, hb_ren}, 32'd0);
      check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      begin
         int seen = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (rsp_valid) seen++;
         end
         check("rst_mid_no_rsp", seen, 32'd0);
      end
      check("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);

      check("never_both_strobes", both_high, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
